// File: rtl/double_pkg.sv
// Shared definitions for the handshaked binary64 FPU components.
//   - binary64 field widths and the all-ones exponent
//   - canonical quiet NaN returned when no ordered operand exists
//   - stb/ack wrapper FSM state encoding
//   - is_nan / is_zero classification helpers
package double_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 11;
  localparam int MANT_W = 52;
  localparam int DBL_W  = SIGN_W + EXP_W + MANT_W;

  localparam logic [EXP_W-1:0] EXP_ONES   = '1;
  localparam logic [DBL_W-1:0] CANON_QNAN = 64'h7FF8000000000000;

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    COMPARE = 2'd2,
    PUT_Z   = 2'd3
  } state_t;

  function automatic logic is_nan(input logic [DBL_W-1:0] x);
    return (x[DBL_W-2 -: EXP_W] == EXP_ONES) && (x[MANT_W-1:0] != '0);
  endfunction

  // Either signed zero.
  function automatic logic is_zero(input logic [DBL_W-1:0] x);
    return x[DBL_W-2:0] == '0;
  endfunction

endpackage

// File: rtl/double_max_core.sv
// Combinational IEEE 754-2008 maxNum on binary64.
//   a, b      : operands
//   z         : maximum (non-NaN operand if exactly one is NaN,
//               canonical qNaN if both are, +0 for mixed-sign zeros)
//   unordered : at least one operand is NaN
module double_max_core
  import double_pkg::*;
(
  input  logic [DBL_W-1:0] a,
  input  logic [DBL_W-1:0] b,
  output logic [DBL_W-1:0] z,
  output logic             unordered
);

  logic             a_nan, b_nan;
  logic [DBL_W-2:0] a_mag, b_mag;

  assign a_nan = is_nan(a);
  assign b_nan = is_nan(b);
  assign a_mag = a[DBL_W-2:0];
  assign b_mag = b[DBL_W-2:0];

  always_comb begin
    z         = a;
    unordered = 1'b0;
    if (a_nan && b_nan) begin
      z         = CANON_QNAN;
      unordered = 1'b1;
    end else if (a_nan) begin
      z         = b;
      unordered = 1'b1;
    end else if (b_nan) begin
      z         = a;
      unordered = 1'b1;
    end else if (is_zero(a) && is_zero(b) && (a[DBL_W-1] != b[DBL_W-1])) begin
      z = '0;
    end else if (a[DBL_W-1] != b[DBL_W-1]) begin
      z = a[DBL_W-1] ? b : a;
    end else if (!a[DBL_W-1]) begin
      // Both positive: larger magnitude wins; ties keep A.
      z = (b_mag > a_mag) ? b : a;
    end else begin
      // Both negative: smaller magnitude wins; ties keep A.
      z = (b_mag < a_mag) ? b : a;
    end
  end

endmodule

// File: rtl/double_max_hs.sv
// stb/ack stream wrapper around double_max_core. One operation in flight:
// A is taken, then B, one compare cycle, then Z is offered until acked.
//   clk, rst_n          : clock, async active-low reset
//   input_a/_stb/_ack   : operand A channel (ack registered)
//   input_b/_stb/_ack   : operand B channel (ack registered)
//   output_z/_stb/_ack  : result channel with back-pressure
//   output_z_unordered  : a NaN operand was seen, valid with output_z_stb
module double_max_hs
  import double_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DBL_W-1:0] input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  input  logic [DBL_W-1:0] input_b,
  input  logic             input_b_stb,
  output logic             input_b_ack,
  output logic [DBL_W-1:0] output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic             output_z_unordered
);

  state_t           state_q, state_d;
  logic [DBL_W-1:0] a_q, a_d, b_q, b_d, z_q, z_d;
  logic             unord_q, unord_d;
  logic             a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;

  logic [DBL_W-1:0] core_z;
  logic             core_unord;

  double_max_core u_core (
    .a         (a_q),
    .b         (b_q),
    .z         (core_z),
    .unordered (core_unord)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    unord_d = unord_q;
    a_ack_d = a_ack_q;
    b_ack_d = b_ack_q;
    z_stb_d = z_stb_q;
    case (state_q)
      GET_A: begin
        // Ack comes up one cycle after reset release; it is computed
        // one cycle ahead so the port itself is a flop.
        a_ack_d = 1'b1;
        if (input_a_stb && a_ack_q) begin
          a_d     = input_a;
          a_ack_d = 1'b0;
          b_ack_d = 1'b1;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (input_b_stb && b_ack_q) begin
          b_d     = input_b;
          b_ack_d = 1'b0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        z_d     = core_z;
        unord_d = core_unord;
        z_stb_d = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (z_stb_q && output_z_ack) begin
          z_stb_d = 1'b0;
          a_ack_d = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
      unord_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      z_stb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      unord_q <= unord_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      z_stb_q <= z_stb_d;
    end
  end

  assign input_a_ack        = a_ack_q;
  assign input_b_ack        = b_ack_q;
  assign output_z           = z_q;
  assign output_z_stb       = z_stb_q;
  assign output_z_unordered = unord_q;

endmodule

// File: tb/tb_double_max_hs.sv
// Directed vectors, hand sequences for latency / back-pressure / ordering /
// reset, and randomized pairs against an ordered-key reference model.
module tb_double_max_hs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] input_a, input_b;
  logic        input_a_stb, input_b_stb, output_z_ack;
  logic        input_a_ack, input_b_ack, output_z_stb, output_z_unordered;
  logic [63:0] output_z;

  always #5 clk = ~clk;

  double_max_hs dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .input_a            (input_a),
    .input_a_stb        (input_a_stb),
    .input_a_ack        (input_a_ack),
    .input_b            (input_b),
    .input_b_stb        (input_b_stb),
    .input_b_ack        (input_b_ack),
    .output_z           (output_z),
    .output_z_stb       (output_z_stb),
    .output_z_ack       (output_z_ack),
    .output_z_unordered (output_z_unordered)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] z;
    logic        u;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  // Reference maxNum: map sign-magnitude to an unsigned ordered key,
  // in which +0 already ranks above -0.
  function automatic logic [64:0] ref_max(input logic [63:0] a, input logic [63:0] b);
    logic an, bn;
    logic [63:0] ka, kb;
    an = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    bn = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    if (an && bn) return {1'b1, 64'h7FF8000000000000};
    if (an)       return {1'b1, b};
    if (bn)       return {1'b1, a};
    ka = a[63] ? ~a : (a | 64'h8000000000000000);
    kb = b[63] ? ~b : (b | 64'h8000000000000000);
    return {1'b0, (kb > ka) ? b : a};
  endfunction

  task automatic send_a(input logic [63:0] v, input int gap);
    bit ok = 0;
    repeat (gap) @(negedge clk);
    input_a     = v;
    input_a_stb = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (input_a_ack) begin
        @(posedge clk);
        ok = 1;
      end else @(negedge clk);
    end
    #1 input_a_stb = 1'b0;
    if (!ok) timeout("send_a");
  endtask

  task automatic send_b(input logic [63:0] v, input int gap);
    bit ok = 0;
    repeat (gap) @(negedge clk);
    input_b     = v;
    input_b_stb = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (input_b_ack) begin
        @(posedge clk);
        ok = 1;
      end else @(negedge clk);
    end
    #1 input_b_stb = 1'b0;
    if (!ok) timeout("send_b");
  endtask

  task automatic wait_z(output bit ok);
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (output_z_stb) ok = 1;
    end
    if (!ok) timeout("wait_z");
  endtask

  // Waits for Z, holds ack low for gap cycles, then completes one transfer.
  task automatic get_z(input int gap, output logic [63:0] z, output logic u);
    bit ok;
    wait_z(ok);
    repeat (gap) @(negedge clk);
    z = output_z;
    u = output_z_unordered;
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int ga,
                        input int gb, input int gz, output logic [63:0] z, output logic u);
    send_a(a, ga);
    send_b(b, gb);
    get_z(gz, z, u);
  endtask

  function automatic logic [63:0] rand_op();
    logic [63:0] r;
    logic [51:0] m;
    r = {$urandom, $urandom};
    m = r[51:0];
    case ($urandom_range(0, 5))
      0: return r;
      1: return {r[63], 11'h000, m};
      2: return {r[63], 11'h7FF, 52'd0};
      3: return {r[63], 63'd0};
      4: return {r[63], 11'h7FF, (m == 52'd0) ? 52'd1 : m};
      default: return {r[63], 11'h3FF + 11'(r[3:0]), m};
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] z, z0, a, b;
    logic        u;
    logic [64:0] exp;
    bit          ok;

    vecs.push_back('{64'h3FF0000000000000, 64'h4000000000000000, 64'h4000000000000000, 1'b0});
    vecs.push_back('{64'h8000000000000000, 64'h0000000000000000, 64'h0000000000000000, 1'b0});
    vecs.push_back('{64'h0000000000000000, 64'h8000000000000000, 64'h0000000000000000, 1'b0});
    vecs.push_back('{64'h8000000000000000, 64'h8000000000000000, 64'h8000000000000000, 1'b0});
    vecs.push_back('{64'hC008000000000000, 64'hC000000000000000, 64'hC000000000000000, 1'b0});
    vecs.push_back('{64'h7FF8000000000001, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1});
    vecs.push_back('{64'h3FF0000000000000, 64'hFFF8000000000000, 64'h3FF0000000000000, 1'b1});
    vecs.push_back('{64'h7FF0000000000001, 64'hFFF8000000000000, 64'h7FF8000000000000, 1'b1});
    vecs.push_back('{64'h7FF0000000000000, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000, 1'b0});
    vecs.push_back('{64'hFFF0000000000000, 64'h8000000000000001, 64'h8000000000000001, 1'b0});
    vecs.push_back('{64'h0000000000000001, 64'h0000000000000002, 64'h0000000000000002, 1'b0});
    vecs.push_back('{64'hBFF0000000000000, 64'h0000000000000000, 64'h0000000000000000, 1'b0});
    vecs.push_back('{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0});

    rst_n = 1'b0;
    input_a = '0; input_b = '0;
    input_a_stb = 1'b0; input_b_stb = 1'b0; output_z_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_ack", input_a_ack, 0);
    chk("rst_b_ack", input_b_ack, 0);
    chk("rst_z_stb", output_z_stb, 0);
    chk("rst_z", output_z, 0);
    chk("rst_unord", output_z_unordered, 0);
    rst_n = 1'b1;
    #1 chk("rel_a_ack_low", input_a_ack, 0);
    @(negedge clk);
    chk("rel_a_ack_high", input_a_ack, 1);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 0, 0, 0, z, u);
      chk($sformatf("vec%0d_z", i), z, vecs[i].z);
      chk($sformatf("vec%0d_u", i), u, vecs[i].u);
    end

    // Latency: stb low in the COMPARE cycle, high the cycle after
    send_a(64'h3FF0000000000000, 0);
    @(negedge clk);
    input_b = 64'h4000000000000000;
    input_b_stb = 1'b1;
    ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (input_b_ack) ok = 1; else @(negedge clk);
    end
    if (!ok) timeout("lat_b");
    @(negedge clk);
    input_b_stb = 1'b0;
    chk("lat_compare_stb", output_z_stb, 0);
    @(negedge clk);
    chk("lat_put_stb", output_z_stb, 1);
    chk("lat_z", output_z, 64'h4000000000000000);
    get_z(0, z, u);

    // Back-pressure
    send_a(64'hC008000000000000, 1);
    send_b(64'h4014000000000000, 2);
    wait_z(ok);
    z0 = output_z;
    chk("bp_z0", z0, 64'h4014000000000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stb", output_z_stb, 1);
      chk("bp_z", output_z, z0);
      chk("bp_a_ack", input_a_ack, 0);
      chk("bp_b_ack", input_b_ack, 0);
    end
    output_z_ack = 1'b1;
    @(posedge clk);
    #1 output_z_ack = 1'b0;
    @(negedge clk);
    chk("bp_stb_drop", output_z_stb, 0);
    chk("bp_a_ack_back", input_a_ack, 1);

    // Ordering: early B stb is not acked until A transfers
    @(negedge clk);
    input_b = 64'hC000000000000000;
    input_b_stb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ord_b_wait", input_b_ack, 0);
    end
    send_a(64'hC008000000000000, 0);
    send_b(64'hC000000000000000, 0);
    get_z(0, z, u);
    chk("ord_z", z, 64'hC000000000000000);
    chk("ord_u", u, 0);

    // Reset while in PUT_Z
    send_a(64'h4000000000000000, 0);
    send_b(64'h3FF0000000000000, 0);
    wait_z(ok);
    rst_n = 1'b0;
    #1;
    chk("midrst_stb", output_z_stb, 0);
    chk("midrst_z", output_z, 0);
    chk("midrst_u", output_z_unordered, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'h8000000000000001, 64'h7FF0000000000001, 0, 0, 0, z, u);
    chk("post_rst_z", z, 64'h8000000000000001);
    chk("post_rst_u", u, 1);

    // Random pairs with random gaps
    for (int i = 0; i < 300; i++) begin
      a = rand_op();
      b = ($urandom_range(0, 9) == 0) ? a : rand_op();
      exp = ref_max(a, b);
      run_op(a, b, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3), z, u);
      chk($sformatf("rnd%0d_z a=%h b=%h", i, a, b), z, exp[63:0]);
      chk($sformatf("rnd%0d_u", i), u, exp[64]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
